alu_cmd_sequencer: RTL

Upstream issue stage for the 8-bit ALU (`main`).
- Accepts operand/operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each command into the ALU with the load / persist / reset `in_sel` codes, waits a fixed settle time and captures the ALU output.
- Presents the captured result downstream over a second valid/ready handshake.
- Replaces hand-driven `in_sel`/`num`/`out_sel` stimulus with a queued, back-pressured command path.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 68 ++++++
 rtl/alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - seq_state_t : sequencer FSM states
//   - SEL_*       : ALU in_sel codes {persist, load, reset}
//   - DEF_DW/OPW  : default operand and op-select widths
//   - is_onehot   : exact one-hot test for operation selects (up to 32 bits)
package alu_seq_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_OPW = 7;

  localparam logic [2:0] SEL_NONE    = 3'b000;
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } seq_state_t;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU sequencer.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : synchronous empty (pointers and count to 0)
//   push, din  : write request / entry (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head entry (valid when !empty)
//   full/empty : status
//   count      : occupancy, 0..DEPTH
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: queues commands, drives the ALU with
// load / persist / reset codes, captures the result after a settle time and
// hands it downstream.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (ready = FIFO not full)
//   cmd_num1/num2/op         : operands and one-hot operation
//   cmd_err                  : pulse, the cycle after a non-one-hot command
//   flush                    : synchronous abort/clear, highest priority
//   q_count                  : FIFO occupancy
//   alu_on/in_sel/num*/out_sel : ALU drive, alu_out : ALU result
//   res_valid/res_ready      : result handshake, res_data/res_op : result
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int DW          = DEF_DW,
  parameter int OPW         = DEF_OPW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DW-1:0]          cmd_num1,
  input  logic [DW-1:0]          cmd_num2,
  input  logic [OPW-1:0]         cmd_op,
  output logic                   cmd_err,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   alu_on,
  output logic [2:0]             alu_in_sel,
  output logic [DW-1:0]          alu_num1,
  output logic [DW-1:0]          alu_num2,
  output logic [OPW-1:0]         alu_out_sel,
  input  logic [DW-1:0]          alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic [OPW-1:0]         res_op
);

  localparam int EW   = 2 * DW + OPW;
  localparam int CNTW = $clog2(WAIT_CYCLES + 1);

  seq_state_t      state;
  seq_state_t      state_nx;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [EW-1:0]   fifo_head;

  logic            accept;
  logic            op_ok;
  logic            wait_done;
  logic            res_take;
  logic            clr_pulse;
  logic [CNTW-1:0] cnt;

  logic [DW-1:0]   op_num1;
  logic [DW-1:0]   op_num2;
  logic [OPW-1:0]  op_sel;

  // rst gating keeps cmd_ready low while reset is held.
  assign cmd_ready = rst && !fifo_full && !flush;
  assign accept    = cmd_valid && cmd_ready;
  assign op_ok     = is_onehot(32'(cmd_op));
  assign fifo_push = accept && op_ok;
  assign wait_done = (cnt == CNTW'(WAIT_CYCLES - 1));
  assign res_take  = res_valid && res_ready;

  assign alu_num1    = op_num1;
  assign alu_num2    = op_num2;
  assign alu_out_sel = op_sel;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (fifo_push),
    .din   ({cmd_num1, cmd_num2, cmd_op}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  always_comb begin
    fifo_pop = 1'b0;
    if (!flush && !fifo_empty) begin
      case (state)
        S_IDLE:  fifo_pop = 1'b1;
        S_HOLD:  fifo_pop = res_take;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (!fifo_empty) state_nx = S_ISSUE;
        S_ISSUE: state_nx = S_WAIT;
        S_WAIT:  if (wait_done) state_nx = S_HOLD;
        S_HOLD:  if (res_take) state_nx = fifo_empty ? S_IDLE : S_ISSUE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // The post-flush ALU reset cycle runs while the FSM already sits in IDLE.
  always_comb begin
    alu_on     = 1'b0;
    alu_in_sel = SEL_NONE;
    if (clr_pulse) begin
      alu_on     = 1'b1;
      alu_in_sel = SEL_RESET;
    end else begin
      case (state)
        S_ISSUE: begin
          alu_on     = 1'b1;
          alu_in_sel = SEL_LOAD;
        end
        S_WAIT, S_HOLD: begin
          alu_on     = 1'b1;
          alu_in_sel = SEL_PERSIST;
        end
        default: begin
          alu_on     = 1'b0;
          alu_in_sel = SEL_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_err   <= 1'b0;
      clr_pulse <= 1'b0;
      cnt       <= '0;
      op_num1   <= '0;
      op_num2   <= '0;
      op_sel    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else begin
      cmd_err   <= accept && !op_ok;
      clr_pulse <= flush;
      if (flush) begin
        cnt       <= '0;
        res_valid <= 1'b0;
      end else begin
        if (fifo_pop) begin
          {op_num1, op_num2, op_sel} <= fifo_head;
        end
        if (state == S_ISSUE) begin
          cnt <= '0;
        end else if (state == S_WAIT) begin
          cnt <= cnt + 1'b1;
        end
        if (state == S_WAIT && wait_done) begin
          res_valid <= 1'b1;
          res_data  <= alu_out;
          res_op    <= op_sel;
        end else if (state == S_HOLD && res_take) begin
          res_valid <= 1'b0;
        end
      end
    end
  end

endmodule
